// File: rtl/decod_pkg.sv
// Shared types and constants for the immediate decoder: state enum,
// extension-mode codes, opcode-class masks and the decoded-entry payload.
package decod_pkg;

    localparam int unsigned INSTR_W    = 16;
    localparam int unsigned OPCODE_W   = 5;
    localparam int unsigned PALAVRA_W  = 11;
    localparam int unsigned CONTROLE_W = 2;
    localparam int unsigned CONTAGEM_W = 16;

    // Encoding doubles as the number of occupied buffer entries.
    typedef enum logic [1:0] {
        VAZIO = 2'd0,
        UM    = 2'd1,
        DOIS  = 2'd2
    } estado_t;

    localparam logic [CONTROLE_W-1:0] EXT_SINAL  = 2'b00;
    localparam logic [CONTROLE_W-1:0] EXT_DIR8   = 2'b01;
    localparam logic [CONTROLE_W-1:0] EXT_ESQ8   = 2'b10;
    localparam logic [CONTROLE_W-1:0] EXT_NENHUM = 2'b11;

    // Opcode classes as (mask, value) pairs.
    localparam logic [OPCODE_W-1:0] MASC_ALU    = 5'b11000;
    localparam logic [OPCODE_W-1:0] VAL_ALU     = 5'b00000;
    localparam logic [OPCODE_W-1:0] MASC_SINAL  = 5'b11100;
    localparam logic [OPCODE_W-1:0] VAL_SINAL   = 5'b01000;
    localparam logic [OPCODE_W-1:0] MASC_ESQ8   = 5'b11110;
    localparam logic [OPCODE_W-1:0] VAL_ESQ8    = 5'b01100;
    localparam logic [OPCODE_W-1:0] MASC_DIR8   = 5'b11110;
    localparam logic [OPCODE_W-1:0] VAL_DIR8    = 5'b01110;
    localparam logic [OPCODE_W-1:0] MASC_DESVIO = 5'b11000;
    localparam logic [OPCODE_W-1:0] VAL_DESVIO  = 5'b10000;
    localparam logic [OPCODE_W-1:0] MASC_ILEGAL = 5'b11000;
    localparam logic [OPCODE_W-1:0] VAL_ILEGAL  = 5'b11000;

    typedef struct packed {
        logic [OPCODE_W-1:0]   opcode;
        logic [PALAVRA_W-1:0]  palavra;
        logic [CONTROLE_W-1:0] controle;
        logic                  usa_imediato;
        logic                  ilegal;
    } decod_t;

    function automatic logic classe(input logic [OPCODE_W-1:0] op,
                                    input logic [OPCODE_W-1:0] mascara,
                                    input logic [OPCODE_W-1:0] valor);
        return (op & mascara) == valor;
    endfunction

endpackage

// File: rtl/decod_tabela.sv
// Combinational opcode-class table: splits an instruction word and selects
// the sign-extender mode and immediate usage.
module decod_tabela
    import decod_pkg::*;
(
    input  logic [INSTR_W-1:0] instr,
    output decod_t             campos_c
);

    logic [OPCODE_W-1:0] op;

    assign op = instr[INSTR_W-1:PALAVRA_W];

    always_comb begin
        campos_c.opcode       = op;
        campos_c.palavra      = instr[PALAVRA_W-1:0];
        campos_c.controle     = EXT_NENHUM;
        campos_c.usa_imediato = 1'b0;
        campos_c.ilegal       = 1'b0;
        if (classe(op, MASC_SINAL, VAL_SINAL) || classe(op, MASC_DESVIO, VAL_DESVIO)) begin
            campos_c.controle     = EXT_SINAL;
            campos_c.usa_imediato = 1'b1;
        end else if (classe(op, MASC_ESQ8, VAL_ESQ8)) begin
            campos_c.controle     = EXT_ESQ8;
            campos_c.usa_imediato = 1'b1;
        end else if (classe(op, MASC_DIR8, VAL_DIR8)) begin
            campos_c.controle     = EXT_DIR8;
            campos_c.usa_imediato = 1'b1;
        end else if (classe(op, MASC_ILEGAL, VAL_ILEGAL)) begin
            campos_c.ilegal = 1'b1;
        end
    end

endmodule

// File: rtl/decod_imediato.sv
// Two-entry skid buffer that registers decoded immediate fields for the
// sign-extender. Optional out-transfer counter: DECOD_IMEDIATO_CONTADOR_EN.
module decod_imediato
    import decod_pkg::*;
#(
    parameter int unsigned PROFUNDIDADE = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  instr_valid,
    input  logic [INSTR_W-1:0]    instr,
    output logic                  instr_ready,
    input  logic                  flush,
    output logic                  dec_valid,
    input  logic                  dec_ready,
    output logic [OPCODE_W-1:0]   opcode,
    output logic [PALAVRA_W-1:0]  palavra_entrada,
    output logic [CONTROLE_W-1:0] controle,
    output logic                  usa_imediato,
    output logic                  ilegal
`ifdef DECOD_IMEDIATO_CONTADOR_EN
    ,
    output logic [CONTAGEM_W-1:0] contagem
`endif
);

    estado_t estado, estado_prox;
    logic    entrada, saida;
    logic    carrega_cab, cab_da_cauda, carrega_cauda;
    decod_t  campos_cab, campos_cauda, entrada_cab, cauda;

    assign entrada = instr_valid && instr_ready;
    assign saida   = dec_valid && dec_ready;

    decod_tabela u_tabela_cab (
        .instr    (instr),
        .campos_c (campos_cab)
    );

    decod_tabela u_tabela_cauda (
        .instr    (instr),
        .campos_c (campos_cauda)
    );

    // On a drain from DOIS the second entry moves into the head.
    assign entrada_cab = cab_da_cauda ? cauda : campos_cab;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) estado <= VAZIO;
        else          estado <= estado_prox;
    end

    always_comb begin
        estado_prox   = estado;
        carrega_cab   = 1'b0;
        cab_da_cauda  = 1'b0;
        carrega_cauda = 1'b0;
        if (flush) begin
            estado_prox = VAZIO;
        end else begin
            case (estado)
                VAZIO: begin
                    if (entrada) begin
                        estado_prox = UM;
                        carrega_cab = 1'b1;
                    end
                end
                UM: begin
                    if (entrada && saida) begin
                        carrega_cab = 1'b1;
                    end else if (entrada) begin
                        estado_prox   = DOIS;
                        carrega_cauda = 1'b1;
                    end else if (saida) begin
                        estado_prox = VAZIO;
                    end
                end
                DOIS: begin
                    if (saida) begin
                        estado_prox  = UM;
                        carrega_cab  = 1'b1;
                        cab_da_cauda = 1'b1;
                    end
                end
                default: estado_prox = VAZIO;
            endcase
        end
    end

    // Head entry drives the outputs directly; ready looks only at the next state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dec_valid       <= 1'b0;
            instr_ready     <= 1'b0;
            opcode          <= '0;
            palavra_entrada <= '0;
            controle        <= EXT_NENHUM;
            usa_imediato    <= 1'b0;
            ilegal          <= 1'b0;
            cauda           <= '0;
        end else begin
            dec_valid   <= (estado_prox != VAZIO);
            instr_ready <= (32'(estado_prox) < PROFUNDIDADE);
            if (carrega_cab) begin
                opcode          <= entrada_cab.opcode;
                palavra_entrada <= entrada_cab.palavra;
                controle        <= entrada_cab.controle;
                usa_imediato    <= entrada_cab.usa_imediato;
            end
            if (carrega_cauda) cauda <= campos_cauda;
            if (flush) ilegal <= 1'b0;
            else if (carrega_cab && entrada_cab.ilegal) ilegal <= 1'b1;
        end
    end

`ifdef DECOD_IMEDIATO_CONTADOR_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)   contagem <= '0;
        else if (flush) contagem <= '0;
        else if (saida) contagem <= contagem + CONTAGEM_W'(1);
    end
`endif

endmodule

// File: doc/decod_imediato.md
DECOD_IMEDIATO -- requirements
Module: decod_imediato

Interface
REQ-001 Parameter PROFUNDIDADE, default 2, is the number of skid-buffer entries; only the value 2 is supported.
REQ-002 Port clock, input, 1 bit, is the single clock; all state updates on its rising edge.
REQ-003 Port reset_n, input, 1 bit, is the asynchronous, active-low reset.
REQ-004 Port instr_valid, input, 1 bit: the fetch stage presents an instruction.
REQ-005 Port instr, input, 16 bits: the instruction word.
REQ-006 Port instr_ready, output, 1 bit: the block accepts instr this cycle.
REQ-007 Port flush, input, 1 bit: discard all buffered instructions.
REQ-008 Port dec_valid, output, 1 bit: the decoded fields are valid.
REQ-009 Port dec_ready, input, 1 bit: the downstream stage consumes the fields.
REQ-010 Port opcode, output, 5 bits: equals instr[15:11].
REQ-011 Port palavra_entrada, output, 11 bits: equals instr[10:0]; this is the immediate fed to the sign-extender.
REQ-012 Port controle, output, 2 bits: the extension mode for the sign-extender.
REQ-013 Port usa_imediato, output, 1 bit: the instruction uses an immediate operand.
REQ-014 Port ilegal, output, 1 bit: sticky flag for an illegal opcode.

Function
REQ-015 A transfer in occurs when instr_valid && instr_ready; a transfer out occurs when dec_valid && dec_ready.
REQ-016 Latency from transfer in to dec_valid is exactly 1 cycle when the buffer was empty.
REQ-017 Decode table (opcode -> controle / usa_imediato):
- 00xxx -> 11 / 0 (register ALU op)
- 010xx -> 00 / 1 (sign-extend)
- 0110x -> 10 / 1 (shift left 8)
- 0111x -> 01 / 1 (shift right 8)
- 10xxx -> 00 / 1 (branch)
- 11xxx -> 11 / 0 (illegal)
REQ-018 Decoding is registered; all outputs come from the head buffer entry and hold stable while dec_valid && !dec_ready.
REQ-019 The FSM has three states: VAZIO, UM and DOIS.
- VAZIO: in -> UM.
- UM: in without out -> DOIS; out without in -> VAZIO; in and out together -> UM.
- DOIS: out -> UM.
REQ-020 instr_ready is registered and equals 1 in VAZIO and UM, and 0 in DOIS; no combinational path exists from dec_ready to instr_ready.
REQ-021 In state DOIS with an out transfer, the second entry moves to the head in the same cycle.
REQ-022 An illegal instruction propagates with dec_valid=1 and sets ilegal when it reaches the head; ilegal stays set until flush or reset.
REQ-023 flush empties the buffer and goes to VAZIO on the next edge, setting dec_valid=0 and ilegal=0; flush has priority over a simultaneous transfer in, and the incoming instruction is dropped.
REQ-024 flush asserted in VAZIO has no effect other than clearing ilegal.

Reset
REQ-025 reset_n low asynchronously sets: state VAZIO, dec_valid=0, instr_ready=0, opcode=0, palavra_entrada=0, controle=2'b11, usa_imediato=0, ilegal=0.
REQ-026 instr_ready rises on the first clock edge after reset_n deasserts.
REQ-027 Reset asserted mid-transfer discards all buffered data.

Configuration
REQ-028 With macro DECOD_IMEDIATO_CONTADOR_EN defined, a 16-bit output contagem counts out transfers. It wraps 16'hFFFF -> 0, resets to 0, and is cleared by flush.
REQ-029 Without DECOD_IMEDIATO_CONTADOR_EN, neither the port contagem nor its logic exists.

Structure
REQ-030 Package decod_pkg holds:
- the state enum (VAZIO/UM/DOIS)
- controle constants EXT_SINAL=00, EXT_DIR8=01, EXT_ESQ8=10, EXT_NENHUM=11
- the opcode-class masks
REQ-031 Sub-module decod_tabela implements the combinational REQ-017 table, one instance per buffer entry input.

Verification
REQ-032 Reset release, then instr=16'h5405 valid, dec_ready=1 -> next cycle dec_valid=1, opcode=5'h0A, palavra_entrada=11'h405, controle=00, usa_imediato=1.
REQ-033 instr=16'h60AB -> controle=10, palavra_entrada=11'h0AB; instr=16'h7123 -> controle=01.
REQ-034 dec_ready=0, then three instructions offered -> first two accepted, instr_ready=0 after the second; dec_ready=1 -> both are delivered in order and instr_ready=1.
REQ-035 instr=16'hF800 -> ilegal=1 and controle=11; ilegal stays set after later legal instructions; flush -> ilegal=0, dec_valid=0.
REQ-036 Buffer in DOIS, with flush and instr_valid asserted in the same cycle -> state VAZIO and the incoming word is never output.
REQ-037 With DECOD_IMEDIATO_CONTADOR_EN defined, contagem preloaded at 16'hFFFF plus one out transfer -> contagem=0; reset_n pulsed mid-stream -> all outputs at their REQ-025 values.
